accum_share_ctrl: RTL and testbench

//  Round-robin scheduler sharing one accum instance (IN_WIDTH/OUT_WIDTH) among N_REQ requesters.

---
 rtl/accum_share_ctrl.sv | 131 +++++++++++++
 tb/tb_accum_share_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_share_ctrl.sv
// Round-robin controller that time-shares one accumulator among N_REQ burst requesters:
// clear, stream the granted requester's samples, then hand back the tagged sum.
module accum_share_ctrl #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned LEN_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid_i,
  input  logic [N_REQ*LEN_WIDTH-1:0] req_len_i,
  output logic [N_REQ-1:0]           grant_o,
  input  logic [N_REQ-1:0]           s_valid_i,
  input  logic [N_REQ*IN_WIDTH-1:0]  s_data_i,
  output logic [N_REQ-1:0]           s_ready_o,
  output logic                       acc_rst_o,
  output logic                       acc_en_o,
  output logic [IN_WIDTH-1:0]        acc_data_in_o,
  input  logic [OUT_WIDTH-1:0]       acc_data_out_i,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic [OUT_WIDTH-1:0]       res_data_o,
  output logic [$clog2(N_REQ)-1:0]   res_id_o
);

  localparam int unsigned IdW = $clog2(N_REQ);

  typedef enum logic [1:0] {StIdle, StClear, StStream, StResult} state_e;

  state_e               state_q, state_d;
  logic [IdW-1:0]       ptr_q, ptr_d;
  logic [IdW-1:0]       gnt_q, gnt_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;

  logic                 pick_found;
  logic [IdW-1:0]       pick_idx;
  logic                 beat;

  // First requester at or after the pointer, wrapping around.
  always_comb begin : rr_pick
    int unsigned cand;
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    cand       = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = (int'(ptr_q) + k) % N_REQ;
      if (!pick_found && req_valid_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IdW'(cand);
      end
    end
  end

  assign beat = (state_q == StStream) && s_valid_i[gnt_q];

  always_comb begin : next_state
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          gnt_d   = pick_idx;
          cnt_d   = req_len_i[int'(pick_idx)*LEN_WIDTH +: LEN_WIDTH];
          state_d = StClear;
        end
      end
      StClear: begin
        state_d = (cnt_q != '0) ? StStream : StResult;
      end
      StStream: begin
        if (beat) begin
          cnt_d = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) begin
            state_d = StResult;
          end
        end
      end
      StResult: begin
        if (res_ready_i) begin
          ptr_d   = (gnt_q == IdW'(N_REQ - 1)) ? '0 : gnt_q + IdW'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin : outputs
    grant_o       = '0;
    s_ready_o     = '0;
    acc_en_o      = beat;
    acc_data_in_o = '0;
    res_valid_o   = (state_q == StResult);
    res_data_o    = '0;
    res_id_o      = '0;
    if (state_q != StIdle) begin
      grant_o[gnt_q] = 1'b1;
    end
    if (state_q == StStream) begin
      s_ready_o[gnt_q] = 1'b1;
    end
    if (beat) begin
      acc_data_in_o = s_data_i[int'(gnt_q)*IN_WIDTH +: IN_WIDTH];
    end
    if (res_valid_o) begin
      res_data_o = acc_data_out_i;
      res_id_o   = gnt_q;
    end
  end

  // Reset always clears the accumulator, independent of FSM state.
  assign acc_rst_o = rst | (state_q == StClear);

endmodule

// File: tb/tb_accum_share_ctrl.sv
// Bench for accum_share_ctrl with a behavioural accumulator and a round-robin reference model.
module tb_accum_share_ctrl;

  localparam int N  = 4;
  localparam int IW = 16;
  localparam int OW = 16;
  localparam int LW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid_i;
  logic [N*LW-1:0]   req_len_i;
  logic [N-1:0]      grant_o;
  logic [N-1:0]      s_valid_i;
  logic [N*IW-1:0]   s_data_i;
  logic [N-1:0]      s_ready_o;
  logic              acc_rst_o;
  logic              acc_en_o;
  logic [IW-1:0]     acc_data_in_o;
  logic [OW-1:0]     acc_data_out_i;
  logic              res_valid_o;
  logic              res_ready_i;
  logic [OW-1:0]     res_data_o;
  logic [1:0]        res_id_o;

  accum_share_ctrl #(
    .N_REQ    (N),
    .IN_WIDTH (IW),
    .OUT_WIDTH(OW),
    .LEN_WIDTH(LW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .req_len_i     (req_len_i),
    .grant_o       (grant_o),
    .s_valid_i     (s_valid_i),
    .s_data_i      (s_data_i),
    .s_ready_o     (s_ready_o),
    .acc_rst_o     (acc_rst_o),
    .acc_en_o      (acc_en_o),
    .acc_data_in_o (acc_data_in_o),
    .acc_data_out_i(acc_data_out_i),
    .res_valid_o   (res_valid_o),
    .res_ready_i   (res_ready_i),
    .res_data_o    (res_data_o),
    .res_id_o      (res_id_o)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared accumulator datapath.
  always_ff @(posedge clk) begin
    if (acc_rst_o) acc_data_out_i <= '0;
    else if (acc_en_o) acc_data_out_i <= acc_data_out_i + acc_data_in_o;
  end

  int          n_assert = 0;
  int          n_fail   = 0;
  int          ptr_m    = 0;
  bit          pend [N];
  int          lens [N];
  logic [15:0] smp  [N][16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic post_req(input int i, input int len);
    pend[i] = 1'b1;
    lens[i] = len;
    req_valid_i[i] = 1'b1;
    req_len_i[i*LW +: LW] = LW'(len);
  endtask

  // gap_mode: 0 back-to-back, 1 alternate valid, 2 random gaps.
  task automatic serve_one(input int gap_mode, input int bp);
    int          exp_id;
    int          len;
    int          beats;
    int          cyc;
    logic        v;
    logic [15:0] exp_sum;
    exp_id = -1;
    for (int k = 0; k < N; k++) begin
      if (exp_id < 0 && pend[(ptr_m + k) % N]) exp_id = (ptr_m + k) % N;
    end
    if (exp_id < 0) exp_id = 0;
    cyc = 0;
    while (grant_o == '0 && cyc < 6) begin
      @(negedge clk);
      cyc++;
    end
    chk("grant", 32'(grant_o), 32'(1 << exp_id));
    chk("clear_acc_rst", 32'(acc_rst_o), 32'd1);
    chk("clear_s_ready", 32'(s_ready_o), 32'd0);
    req_valid_i[exp_id] = 1'b0;
    pend[exp_id] = 1'b0;
    len = lens[exp_id];
    exp_sum = '0;
    for (int b = 0; b < len; b++) exp_sum = exp_sum + smp[exp_id][b];
    beats = 0;
    cyc = 0;
    @(negedge clk);
    while (beats < len && cyc < 400) begin
      chk("stream_s_ready", 32'(s_ready_o), 32'(1 << exp_id));
      chk("stream_res_valid", 32'(res_valid_o), 32'd0);
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      s_valid_i = N'($urandom);
      s_valid_i[exp_id] = v;
      s_data_i = {$urandom, $urandom};
      s_data_i[exp_id*IW +: IW] = smp[exp_id][beats];
      #1;
      chk("acc_en", 32'(acc_en_o), 32'(v));
      chk("acc_data_in", 32'(acc_data_in_o), v ? 32'(smp[exp_id][beats]) : 32'd0);
      @(negedge clk);
      if (v) beats++;
      cyc++;
    end
    if (beats < len) chk("stream_timeout", beats, len);
    s_valid_i = '0;
    chk("res_valid", 32'(res_valid_o), 32'd1);
    chk("res_data", 32'(res_data_o), 32'(exp_sum));
    chk("res_id", 32'(res_id_o), 32'(exp_id));
    chk("res_acc_en", 32'(acc_en_o), 32'd0);
    chk("res_acc_rst", 32'(acc_rst_o), 32'd0);
    chk("res_s_ready", 32'(s_ready_o), 32'd0);
    for (int b = 0; b < bp; b++) begin
      @(negedge clk);
      chk("hold_res_valid", 32'(res_valid_o), 32'd1);
      chk("hold_res_data", 32'(res_data_o), 32'(exp_sum));
      chk("hold_acc_en", 32'(acc_en_o), 32'd0);
    end
    res_ready_i = 1'b1;
    @(negedge clk);
    res_ready_i = 1'b0;
    chk("done_res_valid", 32'(res_valid_o), 32'd0);
    chk("done_grant", 32'(grant_o), 32'd0);
    ptr_m = (exp_id + 1) % N;
  endtask

  initial begin
    int cnt;
    int mask;
    rst = 1'b1;
    req_valid_i = '0;
    req_len_i = '0;
    s_valid_i = '0;
    s_data_i = '0;
    res_ready_i = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_s_ready", 32'(s_ready_o), 32'd0);
    chk("rst_acc_en", 32'(acc_en_o), 32'd0);
    chk("rst_res_valid", 32'(res_valid_o), 32'd0);
    chk("rst_res_id", 32'(res_id_o), 32'd0);
    chk("rst_acc_rst", 32'(acc_rst_o), 32'd1);
    rst = 1'b0;
    #1;
    chk("idle_acc_rst", 32'(acc_rst_o), 32'd0);
    @(negedge clk);

    // Single burst 5,7,9.
    smp[0][0] = 16'd5; smp[0][1] = 16'd7; smp[0][2] = 16'd9;
    post_req(0, 3);
    serve_one(0, 0);

    // All four requesters, one sample each, then 0 and 2 again.
    for (int i = 0; i < N; i++) begin
      smp[i][0] = 16'(i + 1);
      post_req(i, 1);
    end
    for (int i = 0; i < N; i++) serve_one(0, 0);
    smp[0][0] = 16'd11; smp[2][0] = 16'd13;
    post_req(0, 1);
    post_req(2, 1);
    serve_one(0, 0);
    serve_one(0, 0);

    // Zero-length burst on requester 1.
    post_req(1, 0);
    serve_one(0, 0);

    // Bubbles and result backpressure.
    for (int b = 0; b < 4; b++) smp[3][b] = 16'(100 * (b + 1));
    post_req(3, 4);
    serve_one(1, 5);

    // Sum wraps modulo 2**OUT_WIDTH.
    smp[2][0] = 16'hFFFF; smp[2][1] = 16'h0002;
    post_req(2, 2);
    serve_one(0, 0);

    // Random request mixes, lengths, gaps and backpressure.
    for (int r = 0; r < 8; r++) begin
      mask = $urandom_range(1, 15);
      cnt = 0;
      for (int i = 0; i < N; i++) begin
        if (mask[i]) begin
          for (int b = 0; b < 16; b++) smp[i][b] = 16'($urandom);
          post_req(i, $urandom_range(0, 6));
          cnt++;
        end
      end
      for (int k = 0; k < cnt; k++) serve_one(2, $urandom_range(0, 3));
    end

    // Reset after 2 of 4 beats: burst dropped, pointer back to 0.
    for (int b = 0; b < 4; b++) smp[3][b] = 16'h1000;
    post_req(3, 4);
    cnt = 0;
    while (grant_o == '0 && cnt < 6) begin
      @(negedge clk);
      cnt++;
    end
    chk("abort_grant", 32'(grant_o), 32'h8);
    @(negedge clk);
    s_valid_i = 4'b1000;
    s_data_i = '0;
    s_data_i[3*IW +: IW] = 16'h1000;
    repeat (2) @(negedge clk);
    s_valid_i = '0;
    rst = 1'b1;
    req_valid_i = '0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    ptr_m = 0;
    #1;
    chk("abort_acc_rst", 32'(acc_rst_o), 32'd1);
    @(negedge clk);
    chk("abort_grant_clr", 32'(grant_o), 32'd0);
    chk("abort_res_valid", 32'(res_valid_o), 32'd0);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (res_valid_o !== 1'b0) cnt++;
    end
    chk("abort_no_result", cnt, 0);
    smp[1][0] = 16'd3; smp[1][1] = 16'd4; smp[1][2] = 16'd5;
    smp[3][0] = 16'd9;
    post_req(3, 1);
    post_req(1, 3);
    serve_one(0, 0);
    serve_one(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
